// File: rtl/id_ex_register_pkg.sv
// Shared pipeline constants and control-bundle types for the ID/EX pipeline register.
package id_ex_register_pkg;

    localparam int REG_IDX_W    = 5;
    localparam int ALU_CTRL_W   = 3;
    localparam int RESULT_SRC_W = 2;

    typedef enum logic [RESULT_SRC_W-1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef struct packed {
        logic                    reg_write;
        logic                    mem_write;
        logic                    branch;
        logic                    jump;
        logic                    alu_src;
        logic [RESULT_SRC_W-1:0] result_src;
        logic [ALU_CTRL_W-1:0]   alu_control;
    } ctrl_t;

    // A bubble must never carry live control, so invalid entries get an all-zero bundle.
    function automatic ctrl_t ctrl_gate(input logic valid, input ctrl_t ctrl);
        ctrl_t res;
        if (valid) begin
            res = ctrl;
        end else begin
            res = '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/id_ex_register_if.sv
// Decode-to-execute bundle: D-side inputs, pipeline controls and registered E-side outputs.
interface id_ex_register_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    import id_ex_register_pkg::*;

    logic                    Stall_E;
    logic                    Flush_E;

    logic                    Valid_D;
    logic [XLEN-1:0]         PC_D, PCPlus4_D, RD1_D, RD2_D, Imm_Ext_D;
    logic [REG_IDX_W-1:0]    Rs1_D, Rs2_D, Rd_D;
    logic                    RegWrite_D, MemWrite_D, Branch_D, Jump_D, ALUSrc_D;
    logic [RESULT_SRC_W-1:0] ResultSrc_D;
    logic [ALU_CTRL_W-1:0]   ALUControl_D;

    logic                    Valid_E;
    logic [XLEN-1:0]         PC_E, PCPlus4_E, RD1_E, RD2_E, Imm_Ext_E;
    logic [REG_IDX_W-1:0]    Rs1_E, Rs2_E, Rd_E;
    logic                    RegWrite_E, MemWrite_E, Branch_E, Jump_E, ALUSrc_E;
    logic [RESULT_SRC_W-1:0] ResultSrc_E;
    logic [ALU_CTRL_W-1:0]   ALUControl_E;
    logic [CNT_W-1:0]        Bubble_Count_E;

    modport master (
        output Stall_E, Flush_E, Valid_D, PC_D, PCPlus4_D, RD1_D, RD2_D, Imm_Ext_D,
               Rs1_D, Rs2_D, Rd_D, RegWrite_D, MemWrite_D, Branch_D, Jump_D, ALUSrc_D,
               ResultSrc_D, ALUControl_D,
        input  Valid_E, PC_E, PCPlus4_E, RD1_E, RD2_E, Imm_Ext_E, Rs1_E, Rs2_E, Rd_E,
               RegWrite_E, MemWrite_E, Branch_E, Jump_E, ALUSrc_E, ResultSrc_E,
               ALUControl_E, Bubble_Count_E
    );

    modport slave (
        input  Stall_E, Flush_E, Valid_D, PC_D, PCPlus4_D, RD1_D, RD2_D, Imm_Ext_D,
               Rs1_D, Rs2_D, Rd_D, RegWrite_D, MemWrite_D, Branch_D, Jump_D, ALUSrc_D,
               ResultSrc_D, ALUControl_D,
        output Valid_E, PC_E, PCPlus4_E, RD1_E, RD2_E, Imm_Ext_E, Rs1_E, Rs2_E, Rd_E,
               RegWrite_E, MemWrite_E, Branch_E, Jump_E, ALUSrc_E, ResultSrc_E,
               ALUControl_E, Bubble_Count_E
    );

endinterface

// File: rtl/id_ex_register_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_d, count_q;

    // Next count: step on inc unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with flush/stall handling, bubble gating of control and a bubble counter.
module id_ex_register
    import id_ex_register_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    id_ex_register_if.slave   bus
);

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      pc_plus4;
        logic [XLEN-1:0]      rd1;
        logic [XLEN-1:0]      rd2;
        logic [XLEN-1:0]      imm_ext;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
        ctrl_t                ctrl;
    } payload_t;

    payload_t payload_d, payload_q;
    ctrl_t    ctrl_in_s;
    logic     bubble_inc_s;

    assign ctrl_in_s = '{
        reg_write:   bus.RegWrite_D,
        mem_write:   bus.MemWrite_D,
        branch:      bus.Branch_D,
        jump:        bus.Jump_D,
        alu_src:     bus.ALUSrc_D,
        result_src:  bus.ResultSrc_D,
        alu_control: bus.ALUControl_D
    };

    // Next payload: flush beats stall beats load; flushes and invalid loads count as bubbles.
    always_comb begin
        payload_d    = payload_q;
        bubble_inc_s = 1'b0;
        if (bus.Flush_E) begin
            payload_d    = '0;
            bubble_inc_s = 1'b1;
        end else if (bus.Stall_E) begin
            payload_d    = payload_q;
            bubble_inc_s = 1'b0;
        end else begin
            payload_d.valid    = bus.Valid_D;
            payload_d.pc       = bus.PC_D;
            payload_d.pc_plus4 = bus.PCPlus4_D;
            payload_d.rd1      = bus.RD1_D;
            payload_d.rd2      = bus.RD2_D;
            payload_d.imm_ext  = bus.Imm_Ext_D;
            payload_d.rs1      = bus.Rs1_D;
            payload_d.rs2      = bus.Rs2_D;
            payload_d.rd       = bus.Rd_D;
            payload_d.ctrl     = ctrl_gate(bus.Valid_D, ctrl_in_s);
            bubble_inc_s       = ~bus.Valid_D;
        end
    end

    // Payload register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            payload_q <= '0;
        end else begin
            payload_q <= payload_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bubble_inc_s),
        .count (bus.Bubble_Count_E)
    );

    assign bus.Valid_E      = payload_q.valid;
    assign bus.PC_E         = payload_q.pc;
    assign bus.PCPlus4_E    = payload_q.pc_plus4;
    assign bus.RD1_E        = payload_q.rd1;
    assign bus.RD2_E        = payload_q.rd2;
    assign bus.Imm_Ext_E    = payload_q.imm_ext;
    assign bus.Rs1_E        = payload_q.rs1;
    assign bus.Rs2_E        = payload_q.rs2;
    assign bus.Rd_E         = payload_q.rd;
    assign bus.RegWrite_E   = payload_q.ctrl.reg_write;
    assign bus.MemWrite_E   = payload_q.ctrl.mem_write;
    assign bus.Branch_E     = payload_q.ctrl.branch;
    assign bus.Jump_E       = payload_q.ctrl.jump;
    assign bus.ALUSrc_E     = payload_q.ctrl.alu_src;
    assign bus.ResultSrc_E  = payload_q.ctrl.result_src;
    assign bus.ALUControl_E = payload_q.ctrl.alu_control;

endmodule

// File: tb/tb_id_ex_register.sv
// Directed bench for id_ex_register: reset, load, stall, flush, invalid load, back-to-back, saturation.
module tb_id_ex_register;
    import id_ex_register_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [15:0] exp_cnt;
    logic [3:0]  exp4;

    id_ex_register_if #(.XLEN(32), .CNT_W(16)) bus  ();
    id_ex_register_if #(.XLEN(32), .CNT_W(4))  bus4 ();

    id_ex_register #(.XLEN(32), .CNT_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    id_ex_register #(.XLEN(32), .CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic set_idle();
        bus.Stall_E = 1'b0; bus.Flush_E = 1'b0; bus.Valid_D = 1'b1;
        bus.PC_D = 32'h0; bus.PCPlus4_D = 32'h0; bus.RD1_D = 32'h0; bus.RD2_D = 32'h0; bus.Imm_Ext_D = 32'h0;
        bus.Rs1_D = 5'd0; bus.Rs2_D = 5'd0; bus.Rd_D = 5'd0;
        bus.RegWrite_D = 1'b0; bus.MemWrite_D = 1'b0; bus.Branch_D = 1'b0; bus.Jump_D = 1'b0; bus.ALUSrc_D = 1'b0;
        bus.ResultSrc_D = 2'b00; bus.ALUControl_D = 3'b000;
    endtask

    task automatic test_reset();
        @(negedge clk);
        set_idle();
        bus.RegWrite_D = 1'b1; bus.PC_D = 32'h40;
        @(posedge clk); #1;
        checks++; if (bus.Valid_E !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %0b exp 1", bus.Valid_E); end
        #2;
        bus.Stall_E = 1'b1; bus.Flush_E = 1'b1; rst_n = 1'b0;
        #1;
        checks++; if (bus.Valid_E !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", bus.Valid_E); end
        checks++; if (bus.RegWrite_E !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %0b exp 0", bus.RegWrite_E); end
        checks++; if (bus.PC_E !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", bus.PC_E); end
        checks++; if (bus.Bubble_Count_E !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.Bubble_Count_E); end
        exp_cnt = 16'd0;
        @(negedge clk);
        bus.Flush_E = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.Valid_E !== 1'b0) begin errors++; $display("FAIL post_reset_stall_valid got %0b exp 0", bus.Valid_E); end
        checks++; if (bus.PC_E !== 32'h0) begin errors++; $display("FAIL post_reset_stall_pc got %h exp 0", bus.PC_E); end
        checks++; if (bus.Bubble_Count_E !== exp_cnt) begin errors++; $display("FAIL post_reset_stall_count got %0d exp %0d", bus.Bubble_Count_E, exp_cnt); end
        @(negedge clk);
        bus.Stall_E = 1'b0; bus.PC_D = 32'h80;
        @(posedge clk); #1;
        checks++; if (bus.PC_E !== 32'h80) begin errors++; $display("FAIL post_reset_load_pc got %h exp 80", bus.PC_E); end
        checks++; if (bus.RegWrite_E !== 1'b1) begin errors++; $display("FAIL post_reset_load_regwrite got %0b exp 1", bus.RegWrite_E); end
    endtask

    task automatic test_load();
        @(negedge clk);
        set_idle();
        bus.Imm_Ext_D = 32'hFFFFF800; bus.Rd_D = 5'd5; bus.RegWrite_D = 1'b1;
        bus.PC_D = 32'h200; bus.PCPlus4_D = 32'h204; bus.RD1_D = 32'hA5A5_0001; bus.RD2_D = 32'h5A5A_0002;
        bus.Rs1_D = 5'd3; bus.Rs2_D = 5'd7; bus.Jump_D = 1'b1; bus.ALUSrc_D = 1'b1;
        bus.ResultSrc_D = RES_MEM; bus.ALUControl_D = 3'b101;
        @(posedge clk); #1;
        checks++; if (bus.Imm_Ext_E !== 32'hFFFFF800) begin errors++; $display("FAIL load_imm got %h exp fffff800", bus.Imm_Ext_E); end
        checks++; if (bus.Rd_E !== 5'd5) begin errors++; $display("FAIL load_rd got %0d exp 5", bus.Rd_E); end
        checks++; if (bus.RegWrite_E !== 1'b1) begin errors++; $display("FAIL load_regwrite got %0b exp 1", bus.RegWrite_E); end
        checks++; if (bus.Valid_E !== 1'b1) begin errors++; $display("FAIL load_valid got %0b exp 1", bus.Valid_E); end
        checks++; if (bus.PCPlus4_E !== 32'h204) begin errors++; $display("FAIL load_pc4 got %h exp 204", bus.PCPlus4_E); end
        checks++; if (bus.RD2_E !== 32'h5A5A_0002) begin errors++; $display("FAIL load_rd2 got %h exp 5a5a0002", bus.RD2_E); end
        checks++; if (bus.Rs1_E !== 5'd3 || bus.Rs2_E !== 5'd7) begin errors++; $display("FAIL load_rs got %0d/%0d exp 3/7", bus.Rs1_E, bus.Rs2_E); end
        checks++; if (bus.Jump_E !== 1'b1 || bus.ALUSrc_E !== 1'b1 || bus.Branch_E !== 1'b0 || bus.MemWrite_E !== 1'b0) begin
            errors++; $display("FAIL load_ctrl got j%0b a%0b b%0b m%0b exp j1 a1 b0 m0", bus.Jump_E, bus.ALUSrc_E, bus.Branch_E, bus.MemWrite_E); end
        checks++; if (bus.ResultSrc_E !== 2'b01 || bus.ALUControl_E !== 3'b101) begin
            errors++; $display("FAIL load_sel got %b/%b exp 01/101", bus.ResultSrc_E, bus.ALUControl_E); end
        checks++; if (bus.Bubble_Count_E !== exp_cnt) begin errors++; $display("FAIL load_count got %0d exp %0d", bus.Bubble_Count_E, exp_cnt); end
    endtask

    task automatic test_stall();
        @(negedge clk);
        set_idle();
        bus.PC_D = 32'h100;
        @(posedge clk); #1;
        checks++; if (bus.PC_E !== 32'h100) begin errors++; $display("FAIL stall_preload_pc got %h exp 100", bus.PC_E); end
        @(negedge clk);
        bus.Stall_E = 1'b1; bus.PC_D = 32'h104; bus.Valid_D = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.PC_E !== 32'h100) begin errors++; $display("FAIL stall_pc_%0d got %h exp 100", i, bus.PC_E); end
            checks++; if (bus.Valid_E !== 1'b1) begin errors++; $display("FAIL stall_valid_%0d got %0b exp 1", i, bus.Valid_E); end
            checks++; if (bus.Bubble_Count_E !== exp_cnt) begin errors++; $display("FAIL stall_count_%0d got %0d exp %0d", i, bus.Bubble_Count_E, exp_cnt); end
        end
        @(negedge clk);
        bus.Stall_E = 1'b0; bus.Valid_D = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.PC_E !== 32'h104) begin errors++; $display("FAIL stall_release_pc got %h exp 104", bus.PC_E); end
    endtask

    task automatic test_stall_flush();
        @(negedge clk);
        set_idle();
        bus.Stall_E = 1'b1; bus.Flush_E = 1'b1; bus.MemWrite_D = 1'b1; bus.RegWrite_D = 1'b1;
        bus.PC_D = 32'h500; bus.Rd_D = 5'd12;
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 16'd1;
        checks++; if (bus.Valid_E !== 1'b0) begin errors++; $display("FAIL sflush_valid got %0b exp 0", bus.Valid_E); end
        checks++; if (bus.MemWrite_E !== 1'b0 || bus.RegWrite_E !== 1'b0) begin errors++; $display("FAIL sflush_ctrl got m%0b r%0b exp 0", bus.MemWrite_E, bus.RegWrite_E); end
        checks++; if (bus.PC_E !== 32'h0 || bus.Rd_E !== 5'd0) begin errors++; $display("FAIL sflush_data got %h/%0d exp 0/0", bus.PC_E, bus.Rd_E); end
        checks++; if (bus.Bubble_Count_E !== exp_cnt) begin errors++; $display("FAIL sflush_count got %0d exp %0d", bus.Bubble_Count_E, exp_cnt); end
    endtask

    task automatic test_invalid_load();
        @(negedge clk);
        set_idle();
        bus.Valid_D = 1'b0; bus.RegWrite_D = 1'b1; bus.RD1_D = 32'h1234; bus.ResultSrc_D = RES_PC4; bus.Jump_D = 1'b1;
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 16'd1;
        checks++; if (bus.RegWrite_E !== 1'b0) begin errors++; $display("FAIL inv_regwrite got %0b exp 0", bus.RegWrite_E); end
        checks++; if (bus.RD1_E !== 32'h1234) begin errors++; $display("FAIL inv_rd1 got %h exp 1234", bus.RD1_E); end
        checks++; if (bus.Valid_E !== 1'b0 || bus.ResultSrc_E !== 2'b00 || bus.Jump_E !== 1'b0) begin
            errors++; $display("FAIL inv_ctrl got v%0b rs%b j%0b exp 0/00/0", bus.Valid_E, bus.ResultSrc_E, bus.Jump_E); end
        checks++; if (bus.Bubble_Count_E !== exp_cnt) begin errors++; $display("FAIL inv_count got %0d exp %0d", bus.Bubble_Count_E, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        set_idle();
        bus.PC_D = 32'h300; bus.Rd_D = 5'd9; bus.Branch_D = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.PC_E !== 32'h300 || bus.Rd_E !== 5'd9 || bus.Branch_E !== 1'b1) begin
            errors++; $display("FAIL b2b_a got %h/%0d/%0b exp 300/9/1", bus.PC_E, bus.Rd_E, bus.Branch_E); end
        bus.PC_D = 32'h304; bus.Rd_D = 5'd10; bus.Valid_D = 1'b0;
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 16'd1;
        checks++; if (bus.PC_E !== 32'h304 || bus.Rd_E !== 5'd10 || bus.Branch_E !== 1'b0) begin
            errors++; $display("FAIL b2b_b got %h/%0d/%0b exp 304/10/0", bus.PC_E, bus.Rd_E, bus.Branch_E); end
        bus.PC_D = 32'h308; bus.Rd_D = 5'd11; bus.Valid_D = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.PC_E !== 32'h308 || bus.Valid_E !== 1'b1 || bus.Branch_E !== 1'b1) begin
            errors++; $display("FAIL b2b_c got %h/%0b/%0b exp 308/1/1", bus.PC_E, bus.Valid_E, bus.Branch_E); end
        checks++; if (bus.Bubble_Count_E !== exp_cnt) begin errors++; $display("FAIL b2b_count got %0d exp %0d", bus.Bubble_Count_E, exp_cnt); end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (bus4.Bubble_Count_E !== 4'd0) begin errors++; $display("FAIL sat_reset got %0d exp 0", bus4.Bubble_Count_E); end
        @(negedge clk);
        rst_n = 1'b1;
        bus4.Flush_E = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            exp4 = (k < 15) ? 4'(k) : 4'd15;
            checks++; if (bus4.Bubble_Count_E !== exp4) begin errors++; $display("FAIL sat_flush_%0d got %0d exp %0d", k, bus4.Bubble_Count_E, exp4); end
        end
        @(negedge clk);
        bus4.Flush_E = 1'b0; bus4.Valid_D = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus4.Bubble_Count_E !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d exp 15", bus4.Bubble_Count_E); end
    endtask

    initial begin
        checks = 0; errors = 0; exp_cnt = 16'd0; exp4 = 4'd0;
        rst_n = 1'b0;
        set_idle();
        bus4.Stall_E = 1'b0; bus4.Flush_E = 1'b0; bus4.Valid_D = 1'b1;
        bus4.PC_D = 32'h0; bus4.PCPlus4_D = 32'h0; bus4.RD1_D = 32'h0; bus4.RD2_D = 32'h0; bus4.Imm_Ext_D = 32'h0;
        bus4.Rs1_D = 5'd0; bus4.Rs2_D = 5'd0; bus4.Rd_D = 5'd0;
        bus4.RegWrite_D = 1'b0; bus4.MemWrite_D = 1'b0; bus4.Branch_D = 1'b0; bus4.Jump_D = 1'b0; bus4.ALUSrc_D = 1'b0;
        bus4.ResultSrc_D = 2'b00; bus4.ALUControl_D = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_load();
        test_stall();
        test_stall_flush();
        test_invalid_load();
        test_back_to_back();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_register.md
ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of PC, operand and immediate fields.
REQ-002 SHALL have parameter CNT_W, default 16, width of the bubble counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Stall_E  input  1  hold all E-side state.
REQ-006 SHALL have port Flush_E  input  1  replace the incoming entry with a bubble.
REQ-007 SHALL have port Valid_D  input  1  decode entry holds a real instruction.
REQ-008 SHALL have ports PC_D, PCPlus4_D, RD1_D, RD2_D, Imm_Ext_D  input  XLEN each  decode datapath; Imm_Ext_D is the sign extender output.
REQ-009 SHALL have ports Rs1_D, Rs2_D, Rd_D  input  5 each  register indices.
REQ-010 SHALL have ports RegWrite_D, MemWrite_D, Branch_D, Jump_D, ALUSrc_D  input  1 each; ResultSrc_D  input  2; ALUControl_D  input  3  control bundle.
REQ-011 SHALL have one registered output per REQ-007..REQ-010 input, same width, suffix _E instead of _D.
REQ-012 SHALL have port Bubble_Count_E  output  CNT_W  count of bubbles entering EX.

Function
REQ-013 On a clock edge, action priority SHALL be Flush_E, then Stall_E, then load.
REQ-014 Load (Flush_E=0, Stall_E=0): every _E output SHALL take its _D input, latency 1 cycle.
REQ-015 Stall (Flush_E=0, Stall_E=1): every _E output and Bubble_Count_E SHALL hold its value.
REQ-016 Flush (Flush_E=1, any Stall_E): Valid_E and all control outputs SHALL go to 0; datapath and index outputs SHALL go to 0.
REQ-017 Load with Valid_D=0 SHALL force all control outputs to 0 and Valid_E=0, datapath captured as in REQ-014.
REQ-018 Control outputs SHALL never be nonzero while Valid_E=0.
REQ-019 Bubble_Count_E SHALL increment by 1 on each edge that writes Valid_E=0 via flush or load of Valid_D=0.
REQ-020 Bubble_Count_E SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-021 Stall and flush together: flush SHALL win and the counter SHALL increment.
REQ-022 Outputs SHALL be driven only from flops; no combinational path from any input to any output.

Reset
REQ-023 rst_n low SHALL immediately, without clock, clear every _E output and Bubble_Count_E to 0.
REQ-024 Reset asserted mid-stall or mid-flush SHALL override both; first edge after release SHALL follow REQ-013.
REQ-025 Counter SHALL not count reset as a bubble.

Structure
REQ-026 ResultSrc encodings (ALU=00, MEM=01, PC+4=10), ALUControl width and register index width SHALL be constants in the shared pipeline package.
REQ-027 Counter SHALL be sub-module sat_counter (parameter CNT_W; inputs clk, rst_n, inc; output count).
REQ-028 No other sub-modules; one always block for the payload register.

Verification
REQ-029 Reset: rst_n=0 mid-clock with Valid_E=1 -> all outputs 0 before the next edge, Bubble_Count_E=0.
REQ-030 Load: Valid_D=1, Imm_Ext_D=32'hFFFFF800, Rd_D=5, RegWrite_D=1 -> next cycle Imm_Ext_E=32'hFFFFF800, Rd_E=5, RegWrite_E=1, Valid_E=1.
REQ-031 Stall: load PC_D=32'h100, then Stall_E=1 for 3 cycles with PC_D=32'h104 -> PC_E stays 32'h100 three cycles, count unchanged.
REQ-032 Stall+flush: Stall_E=1, Flush_E=1, MemWrite_D=1 -> next cycle Valid_E=0, MemWrite_E=0, Bubble_Count_E incremented by 1.
REQ-033 Invalid load: Valid_D=0, RegWrite_D=1, RD1_D=32'h1234 -> RegWrite_E=0, RD1_E=32'h1234, count +1.
REQ-034 Saturation: CNT_W=4, 20 consecutive flushes -> Bubble_Count_E=15 and holds 15.
